// File: rtl/game_round_sequencer.sv
// -----------------------------------------------------------------------------
// game_round_sequencer
//
// Round and score controller for the bouncing-ball game. It sits above the
// ball motion engine. It gates ball motion (ball_run) and re-serves the ball
// (ball_engine_rst). It watches the ball X position and the collision detector
// to award points and count rallies. The game ends when either side reaches
// WIN_SCORE.
//
// Every output is registered. An input event therefore shows up on the
// outputs exactly one clock later. There is a single clock domain.
//
// Ports
//   clk_25MHZ          in   1        pixel clock
//   reset              in   1        synchronous, active-high, overrides all
//   upscale            in   1        1: 640-wide field, 0: 320-wide field
//   start_btn          in   1        debounced start level (rising edge used)
//   frame_tick         in   1        one-cycle pulse per video frame
//   ball_x_in          in   10       current ball X from the motion engine
//   collision_detected in   1        paddle/ball hit level
//   ball_run           out  1        motion engine may move the ball
//   ball_engine_rst    out  1        one-cycle pulse: re-serve the ball
//   score_p            out  SCORE_W  player score (ball reached right edge)
//   score_c            out  SCORE_W  computer score (ball reached X==0)
//   rally_cnt          out  RALLY_W  hits in the current rally, saturating
//   game_over          out  1        high while in OVER
//   state_out          out  3        IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
// -----------------------------------------------------------------------------
module game_round_sequencer #(
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 5,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 30,
   parameter int RALLY_W      = 8
) (
   input  logic               clk_25MHZ,
   input  logic               reset,
   input  logic               upscale,
   input  logic               start_btn,
   input  logic               frame_tick,
   input  logic [9:0]         ball_x_in,
   input  logic               collision_detected,
   output logic               ball_run,
   output logic               ball_engine_rst,
   output logic [SCORE_W-1:0] score_p,
   output logic [SCORE_W-1:0] score_c,
   output logic [RALLY_W-1:0] rally_cnt,
   output logic               game_over,
   output logic [2:0]         state_out
);

   // Shared frame counter: one counter serves both SERVE and POINT, because
   // only one of those waits can be running at any time.
   localparam int FRAME_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

   localparam logic [FRAME_W-1:0] SERVE_LAST = FRAME_W'(SERVE_FRAMES);
   localparam logic [FRAME_W-1:0] POINT_LAST = FRAME_W'(POINT_FRAMES);
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

   // Right-edge threshold is the field width minus the 20-pixel ball width.
   localparam logic [9:0] R_EDGE_WIDE   = 10'd620;
   localparam logic [9:0] R_EDGE_NARROW = 10'd300;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   state_t state_reg, state_next;

   logic [FRAME_W-1:0] frame_reg,   frame_next;
   logic [SCORE_W-1:0] score_p_reg, score_p_next;
   logic [SCORE_W-1:0] score_c_reg, score_c_next;
   logic [RALLY_W-1:0] rally_reg,   rally_next;

   logic start_d_reg;
   logic coll_d_reg;

   logic ball_run_reg,   ball_run_next;
   logic engine_rst_reg, engine_rst_next;
   logic game_over_reg,  game_over_next;

   logic               start_rise;
   logic               hit_rise;
   logic [9:0]         r_edge;
   logic [FRAME_W-1:0] frame_inc;
   logic               win_reached;

   // Edge detectors. The delayed copies are sampled every cycle in every
   // state, so a level held across a state change never reads as a new edge.
   assign start_rise  = start_btn & ~start_d_reg;
   assign hit_rise    = collision_detected & ~coll_d_reg;

   // upscale may change on any cycle; the threshold follows it directly.
   assign r_edge      = upscale ? R_EDGE_WIDE : R_EDGE_NARROW;
   assign frame_inc   = frame_reg + 1'b1;
   assign win_reached = (score_p_reg == WIN_VAL) || (score_c_reg == WIN_VAL);

   // --------------------------------------------------------------------
   // State and datapath registers
   // --------------------------------------------------------------------
   always_ff @(posedge clk_25MHZ) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         frame_reg      <= '0;
         score_p_reg    <= '0;
         score_c_reg    <= '0;
         rally_reg      <= '0;
         start_d_reg    <= 1'b0;
         coll_d_reg     <= 1'b0;
         ball_run_reg   <= 1'b0;
         engine_rst_reg <= 1'b0;
         game_over_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         frame_reg      <= frame_next;
         score_p_reg    <= score_p_next;
         score_c_reg    <= score_c_next;
         rally_reg      <= rally_next;
         start_d_reg    <= start_btn;
         coll_d_reg     <= collision_detected;
         ball_run_reg   <= ball_run_next;
         engine_rst_reg <= engine_rst_next;
         game_over_reg  <= game_over_next;
      end
   end

   // --------------------------------------------------------------------
   // Next-state and datapath update
   // --------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      frame_next   = frame_reg;
      score_p_next = score_p_reg;
      score_c_next = score_c_reg;
      rally_next   = rally_reg;

      case (state_reg)
         // A new game starts the same way from power-up and after a win.
         ST_IDLE, ST_OVER: begin
            if (start_rise) begin
               state_next   = ST_SERVE;
               frame_next   = '0;
               score_p_next = '0;
               score_c_next = '0;
               rally_next   = '0;
            end
         end

         ST_SERVE: begin
            if (frame_tick) begin
               if (frame_inc == SERVE_LAST) begin
                  state_next = ST_PLAY;
                  frame_next = '0;
               end else begin
                  frame_next = frame_inc;
               end
            end
         end

         // A fresh hit takes priority. When the ball touches the paddle on
         // the same cycle that X reads 0, the hit wins and no point is given.
         ST_PLAY: begin
            if (hit_rise) begin
               if (rally_reg != {RALLY_W{1'b1}}) begin
                  rally_next = rally_reg + 1'b1;
               end
            end else if (ball_x_in == 10'd0) begin
               if (score_c_reg < WIN_VAL) begin
                  score_c_next = score_c_reg + 1'b1;
               end
               state_next = ST_POINT;
               frame_next = '0;
            end else if (ball_x_in >= r_edge) begin
               if (score_p_reg < WIN_VAL) begin
                  score_p_next = score_p_reg + 1'b1;
               end
               state_next = ST_POINT;
               frame_next = '0;
            end
         end

         ST_POINT: begin
            if (frame_tick) begin
               if (frame_inc == POINT_LAST) begin
                  frame_next = '0;
                  if (win_reached) begin
                     state_next = ST_OVER;
                  end else begin
                     state_next = ST_SERVE;
                     rally_next = '0;
                  end
               end else begin
                  frame_next = frame_inc;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
            frame_next = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------
   // Output decode
   // The outputs are decoded from the state being entered and then
   // registered. As a result they change on the same edge as state_out.
   // --------------------------------------------------------------------
   always_comb begin
      ball_run_next   = (state_next == ST_PLAY);
      game_over_next  = (state_next == ST_OVER);
      // Every entry into SERVE re-serves the ball: from IDLE, from OVER and
      // after a point.
      engine_rst_next = (state_next == ST_SERVE) && (state_reg != ST_SERVE);
   end

   assign ball_run        = ball_run_reg;
   assign ball_engine_rst = engine_rst_reg;
   assign score_p         = score_p_reg;
   assign score_c         = score_c_reg;
   assign rally_cnt       = rally_reg;
   assign game_over       = game_over_reg;
   assign state_out       = state_reg;

endmodule

// File: tb/tb_game_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_round_sequencer
//
// Directed bench for game_round_sequencer with default parameters.
// Expected values are worked out by hand in the step sequence below.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_round_sequencer;

   logic       clk_25MHZ          = 1'b0;
   logic       reset              = 1'b1;
   logic       upscale            = 1'b0;
   logic       start_btn          = 1'b0;
   logic       frame_tick         = 1'b0;
   logic [9:0] ball_x_in          = 10'd100;
   logic       collision_detected = 1'b0;

   logic       ball_run;
   logic       ball_engine_rst;
   logic [3:0] score_p;
   logic [3:0] score_c;
   logic [7:0] rally_cnt;
   logic       game_over;
   logic [2:0] state_out;

   int vectors     = 0;
   int miscompares = 0;

   game_round_sequencer dut (
      .clk_25MHZ          (clk_25MHZ),
      .reset              (reset),
      .upscale            (upscale),
      .start_btn          (start_btn),
      .frame_tick         (frame_tick),
      .ball_x_in          (ball_x_in),
      .collision_detected (collision_detected),
      .ball_run           (ball_run),
      .ball_engine_rst    (ball_engine_rst),
      .score_p            (score_p),
      .score_c            (score_c),
      .rally_cnt          (rally_cnt),
      .game_over          (game_over),
      .state_out          (state_out)
   );

   always #20 clk_25MHZ = ~clk_25MHZ;

   // Stop a run that never completes.
   initial begin
      #(40 * 20000);
      $display("FAIL watchdog: run did not complete, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_25MHZ);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int st, input int run, input int ers,
                          input int sp, input int sc, input int rc, input int go);
      chk({tag, ".state"},     32'(state_out),       32'(st));
      chk({tag, ".ball_run"},  32'(ball_run),        32'(run));
      chk({tag, ".engine_rst"},32'(ball_engine_rst), 32'(ers));
      chk({tag, ".score_p"},   32'(score_p),         32'(sp));
      chk({tag, ".score_c"},   32'(score_c),         32'(sc));
      chk({tag, ".rally"},     32'(rally_cnt),       32'(rc));
      chk({tag, ".game_over"}, 32'(game_over),       32'(go));
   endtask

   // Each frame pulse is one cycle, followed by a one-cycle gap.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
      end
   endtask

   initial begin
      // ---- reset ----
      step();
      step();
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      step();
      chk_all("idle", 0, 0, 0, 0, 0, 0, 0);

      // ---- 1: start, serve pulse, 60 ticks to PLAY ----
      start_btn = 1'b1;
      step();
      chk_all("t1_start", 1, 0, 1, 0, 0, 0, 0);
      step();
      chk_all("t1_pulse_end", 1, 0, 0, 0, 0, 0, 0);
      ticks(59);
      chk_all("t1_tick59", 1, 0, 0, 0, 0, 0, 0);
      ticks(1);
      chk_all("t1_play", 2, 1, 0, 0, 0, 0, 0);

      // ---- 2: one hit, then computer point and return to SERVE ----
      collision_detected = 1'b1;
      step();
      chk("t2_hit.rally", 32'(rally_cnt), 32'd1);
      collision_detected = 1'b0;
      step();
      ball_x_in = 10'd0;
      step();
      chk_all("t2_point", 3, 0, 0, 0, 1, 1, 0);
      ball_x_in = 10'd100;
      ticks(29);
      chk_all("t2_tick29", 3, 0, 0, 0, 1, 1, 0);
      frame_tick = 1'b1;
      step();
      chk_all("t2_serve", 1, 0, 1, 0, 1, 0, 0);
      frame_tick = 1'b0;
      step();
      chk("t2_pulse_end.engine_rst", 32'(ball_engine_rst), 32'd0);
      ticks(60);
      chk_all("t2_play", 2, 1, 0, 0, 1, 0, 0);

      // ---- 3: right-edge threshold for both field widths ----
      ball_x_in = 10'd299;
      step();
      chk_all("t3_x299", 2, 1, 0, 0, 1, 0, 0);
      ball_x_in = 10'd300;
      step();
      chk_all("t3_x300_narrow", 3, 0, 0, 1, 1, 0, 0);
      ball_x_in = 10'd100;
      ticks(30);
      ticks(60);
      chk_all("t3_play2", 2, 1, 0, 1, 1, 0, 0);
      upscale = 1'b1;
      ball_x_in = 10'd300;
      step();
      chk_all("t3_x300_wide", 2, 1, 0, 1, 1, 0, 0);
      ball_x_in = 10'd619;
      step();
      chk_all("t3_x619_wide", 2, 1, 0, 1, 1, 0, 0);
      ball_x_in = 10'd620;
      step();
      chk_all("t3_x620_wide", 3, 0, 0, 2, 1, 0, 0);
      ball_x_in = 10'd100;
      upscale = 1'b0;
      ticks(30);
      // A start edge during SERVE must be ignored.
      start_btn = 1'b0;
      step();
      start_btn = 1'b1;
      step();
      chk_all("t3_start_in_serve", 1, 0, 0, 2, 1, 0, 0);
      ticks(60);
      chk_all("t3_play3", 2, 1, 0, 2, 1, 0, 0);

      // ---- 4: rally counting ----
      collision_detected = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk_all("t4_held10", 2, 1, 0, 2, 1, 1, 0);
      collision_detected = 1'b0;
      step();
      collision_detected = 1'b1;
      ball_x_in = 10'd0;
      step();
      chk_all("t4_hit_and_x0", 2, 1, 0, 2, 1, 2, 0);
      ball_x_in = 10'd100;
      collision_detected = 1'b0;
      step();
      for (int i = 0; i < 300; i++) begin
         collision_detected = 1'b1;
         step();
         collision_detected = 1'b0;
         step();
      end
      chk_all("t4_saturate", 2, 1, 0, 2, 1, 255, 0);
      ball_x_in = 10'd0;
      step();
      chk_all("t4_point", 3, 0, 0, 2, 2, 255, 0);
      ball_x_in = 10'd100;
      ticks(30);
      chk_all("t4_serve", 1, 0, 0, 2, 2, 0, 0);
      ticks(60);

      // ---- 5: play out to WIN_SCORE ----
      for (int k = 0; k < 2; k++) begin
         ball_x_in = 10'd300;
         step();
         chk_all("t5_point", 3, 0, 0, 3 + k, 2, 0, 0);
         ball_x_in = 10'd100;
         ticks(30);
         chk_all("t5_serve", 1, 0, 0, 3 + k, 2, 0, 0);
         ticks(60);
      end
      ball_x_in = 10'd300;
      step();
      chk_all("t5_point5", 3, 0, 0, 5, 2, 0, 0);
      ball_x_in = 10'd100;
      ticks(30);
      chk_all("t5_over", 4, 0, 0, 5, 2, 0, 1);
      ticks(3);
      chk_all("t5_over_ticks", 4, 0, 0, 5, 2, 0, 1);
      start_btn = 1'b0;
      step();
      chk_all("t5_over_btn_low", 4, 0, 0, 5, 2, 0, 1);
      start_btn = 1'b1;
      step();
      chk_all("t5_restart", 1, 0, 1, 0, 0, 0, 0);

      // ---- 6: reset mid-POINT and mid-PLAY ----
      ticks(60);
      ball_x_in = 10'd0;
      step();
      chk_all("t6_point", 3, 0, 0, 0, 1, 0, 0);
      ball_x_in = 10'd100;
      ticks(5);
      reset = 1'b1;
      start_btn = 1'b0;
      step();
      chk_all("t6_rst_point", 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      step();
      start_btn = 1'b1;
      step();
      chk_all("t6_restart", 1, 0, 1, 0, 0, 0, 0);
      ticks(60);
      collision_detected = 1'b1;
      step();
      chk_all("t6_play_hit", 2, 1, 0, 0, 0, 1, 0);
      reset = 1'b1;
      collision_detected = 1'b0;
      step();
      chk_all("t6_rst_play", 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      start_btn = 1'b0;
      step();
      chk_all("t6_idle", 0, 0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
